// File: rtl/sram_responder.sv
// Device end of the 16-bit external SRAM bus: stores writes, returns reads after
// READ_LAT registered stages, and records bus conflicts and access counts.
module sram_responder #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int MEM_LOG2 = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_data,
    input  logic [ADDR_W-1:0] SRAM_addr,
    input  logic              SRAM_WE_N,
    output logic              rd_valid,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              bus_conflict
);

    localparam int MEM_WORDS = 1 << MEM_LOG2;

    logic [DATA_W-1:0]   mem [0:MEM_WORDS-1];
    logic [MEM_LOG2-1:0] mem_addr;
    logic                wr_en;
    logic                vld_p  [0:READ_LAT-1];
    logic [DATA_W-1:0]   data_p [0:READ_LAT-1];
    logic                out_v;
    logic [DATA_W-1:0]   out_d;
    logic                drv;

    // High address bits alias onto the same word.
    assign mem_addr = SRAM_addr[MEM_LOG2-1:0];

    generate
        if (ADDR_W > MEM_LOG2) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^SRAM_addr[ADDR_W-1:MEM_LOG2];
        end
    endgenerate

    assign wr_en = rst & ~SRAM_WE_N;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[mem_addr] <= SRAM_data;
        end
    end

    // Stage 0: array read; later stages are a plain shift toward the bus
    always_ff @(posedge clk) begin
        data_p[0] <= mem[mem_addr];
        for (int i = 1; i < READ_LAT; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= SRAM_WE_N;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Output stage: a pending word is only driven while the controller is not writing
    assign out_v     = vld_p[READ_LAT-1];
    assign out_d     = data_p[READ_LAT-1];
    assign drv       = out_v & SRAM_WE_N;
    assign SRAM_data = drv ? out_d : 'z;
    assign rd_valid  = drv;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_count     <= '0;
            rd_count     <= '0;
            bus_conflict <= 1'b0;
        end else begin
            if (!SRAM_WE_N) begin
                wr_count <= wr_count + 16'd1;
            end
            if (drv) begin
                rd_count <= rd_count + 16'd1;
            end
            if (out_v && !SRAM_WE_N) begin
                bus_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed bus scenarios plus random traffic checked
// against a time-indexed return-schedule model of the SRAM.
module tb_sram_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_n;
    logic [17:0] addr;
    logic [15:0] ctl_d;
    logic        ctl_oe;
    wire  [15:0] sram_data;
    wire         rd_valid;
    wire         bus_conflict;
    wire  [15:0] wr_count;
    wire  [15:0] rd_count;

    assign sram_data = ctl_oe ? ctl_d : 16'bz;

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W(18), .DATA_W(16), .MEM_LOG2(16), .READ_LAT(L)
    ) dut (
        .clk(clk), .rst(rst), .SRAM_data(sram_data), .SRAM_addr(addr),
        .SRAM_WE_N(we_n), .rd_valid(rd_valid), .wr_count(wr_count),
        .rd_count(rd_count), .bus_conflict(bus_conflict)
    );

    int checks = 0;
    int errors = 0;

    // Reference: memory image plus a schedule of which edge each read lands on
    bit [15:0]   ref_mem [0:65535];
    bit          slot_v  [0:7];
    bit [15:0]   slot_d  [0:7];
    int unsigned t = 0;
    bit [15:0]   m_wr = 0;
    bit [15:0]   m_rd = 0;
    bit          m_conf = 0;
    bit          chk_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit w, input logic [17:0] a, input logic [15:0] d);
        bit pv;
        t++;
        if (!r) begin
            for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
            m_wr = 0;
            m_rd = 0;
            m_conf = 0;
        end else begin
            pv = slot_v[(t-1)%8];
            if (pv && w)  m_rd++;
            if (pv && !w) m_conf = 1'b1;
            slot_v[(t-1)%8] = 1'b0;
            if (!w) begin
                ref_mem[a[15:0]] = d;
                m_wr++;
            end else begin
                slot_v[(t+L-1)%8] = 1'b1;
                slot_d[(t+L-1)%8] = ref_mem[a[15:0]];
            end
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [17:0] a, input logic [15:0] d);
        bit ev;
        rst = r; we_n = w; addr = a; ctl_d = d; ctl_oe = !w;
        #1;
        if (chk_en) begin
            ev = slot_v[t%8] && w;
            chk("rd_valid", rd_valid, ev);
            if (ev) chk("rd_data", sram_data, slot_d[t%8]);
            chk("wr_count", wr_count, m_wr);
            chk("rd_count", rd_count, m_rd);
            chk("bus_conflict", bus_conflict, m_conf);
        end
        @(posedge clk);
        model_edge(r, w, a, d);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; we_n = 1'b1; addr = '0; ctl_d = '0; ctl_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            slot_v[i] = 1'b0;
            slot_d[i] = '0;
        end
        @(negedge clk);
        repeat (3) step(1'b0, 1'b1, 18'h0, 16'h0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_conflict", bus_conflict, 0);
        chk_en = 1'b1;

        // Fill every word (random upper address bits) so no read sees an unwritten word
        chk_en = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b0, {2'($urandom), 16'(i)}, 16'($urandom));
        end
        chk_en = 1'b1;
        chk("wr_wrap", wr_count, 0);
        chk("wr_wrap_rd", rd_count, 0);

        // Write then read one word
        step(1'b1, 1'b0, 18'h00012, 16'hBEEF);
        step(1'b1, 1'b1, 18'h00012, 16'h0);
        step(1'b1, 1'b1, 18'h00012, 16'h0);
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", sram_data, 16'hBEEF);
        chk("t1_wr", wr_count, 1);
        step(1'b1, 1'b1, 18'h00012, 16'h0);
        chk("t1_rdcnt", rd_count, 1);

        // Streaming reads
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 18'(i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 18'(i), 16'h0);
            if (i >= 1) chk("t2_stream", sram_data, 16'(16'h1111 * i));
        end
        step(1'b1, 1'b1, 18'h0, 16'h0);
        chk("t2_last", sram_data, 16'h4444);

        // Read in flight across a write to the same word
        step(1'b1, 1'b0, 18'h7, 16'hAAAA);
        step(1'b1, 1'b1, 18'h7, 16'h0);
        step(1'b1, 1'b0, 18'h7, 16'h5555);
        we_n = 1'b1; ctl_oe = 1'b0;
        #1;
        chk("t3_old_valid", rd_valid, 1);
        chk("t3_old_data", sram_data, 16'hAAAA);
        step(1'b1, 1'b1, 18'h7, 16'h0);
        step(1'b1, 1'b1, 18'h7, 16'h0);
        chk("t3_new_data", sram_data, 16'h5555);

        // Reset with reads in flight
        step(1'b1, 1'b1, 18'h12, 16'h0);
        step(1'b1, 1'b1, 18'h12, 16'h0);
        step(1'b0, 1'b1, 18'h12, 16'h0);
        chk("t5_valid", rd_valid, 0);
        chk("t5_wr", wr_count, 0);
        chk("t5_rd", rd_count, 0);
        chk("t5_conf", bus_conflict, 0);
        step(1'b1, 1'b1, 18'h3, 16'h0);
        chk("t5_flushed", rd_valid, 0);
        step(1'b1, 1'b1, 18'h3, 16'h0);
        chk("t5_kept_valid", rd_valid, 1);
        chk("t5_kept_data", sram_data, 16'h4444);

        // Write in the cycle a read returns
        we_n = 1'b0; ctl_oe = 1'b1; ctl_d = 16'h1234; addr = 18'h20;
        #1;
        chk("t4_not_driven", rd_valid, 0);
        step(1'b1, 1'b0, 18'h20, 16'h1234);
        chk("t4_conflict", bus_conflict, 1);
        chk("t4_rdcnt", rd_count, 0);
        step(1'b1, 1'b1, 18'h20, 16'h0);
        step(1'b1, 1'b1, 18'h20, 16'h0);
        chk("t4_wr_done", sram_data, 16'h1234);
        chk("t4_sticky", bus_conflict, 1);

        // Address aliasing
        step(1'b1, 1'b0, 18'h10005, 16'hCAFE);
        step(1'b1, 1'b1, 18'h00005, 16'h0);
        step(1'b1, 1'b1, 18'h00005, 16'h0);
        chk("t6_alias", sram_data, 16'hCAFE);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 100) != 0, ($urandom % 3) != 0,
                 18'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
